// File: rtl/stream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_arb_pkg
// Purpose  : Shared arbitration-mode constants for the stream arbiter mux.
// Revision : 1.0 - initial release
// ============================================================================
package stream_arb_pkg;

  // Arbitration modes selectable through the p_mode parameter
  localparam int ARB_FIXED = 0;  // lowest channel index always wins
  localparam int ARB_RR    = 1;  // search starts just past the last winner

endpackage : stream_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating priority picker. Rotates the request
//            vector so that channel ptr sits at bit 0, isolates the lowest
//            set bit, then rotates the one-hot grant back into place.
//            Built from bitwise/arithmetic operators only, so an unknown
//            request bit yields an unknown grant rather than a guess.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int p_nchan = 4
) (
  input  logic [p_nchan-1:0]         req,
  input  logic [$clog2(p_nchan)-1:0] ptr,
  output logic [p_nchan-1:0]         grant,
  output logic [$clog2(p_nchan)-1:0] idx
);

  localparam int                   c_iw  = $clog2(p_nchan);
  localparam logic [c_iw:0]        c_n   = (c_iw+1)'(p_nchan);
  localparam logic [p_nchan-1:0]   c_one = p_nchan'(1);
  localparam logic [c_iw-1:0]      c_top = c_iw'(p_nchan-1);

  // Doubled vectors let a variable part-select act as a rotate; the one
  // bit a rotate can never reach is left off so nothing dangles.
  logic [2*p_nchan-2:0] w_req_dbl;
  logic [2*p_nchan-2:0] w_gnt_dbl;
  logic [p_nchan-1:0]   w_req_rot;
  logic [p_nchan-1:0]   w_gnt_rot;
  logic [c_iw-1:0]      w_rot_idx;
  logic [c_iw:0]        w_sum;

  // Rotate right by ptr: w_req_rot[j] = req[(j+ptr) mod p_nchan]
  assign w_req_dbl = {req[p_nchan-2:0], req};
  assign w_req_rot = w_req_dbl[ptr +: p_nchan];

  // Lowest set bit of the rotated request (x & -x)
  assign w_gnt_rot = w_req_rot & (~w_req_rot + c_one);

  // Rotate left by ptr: grant[i] = w_gnt_rot[(i-ptr) mod p_nchan]
  assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot[p_nchan-1:1]};
  assign grant     = w_gnt_dbl[(c_top - ptr) +: p_nchan];

  // One-hot to binary of the rotated grant, OR-reduced per index
  always_comb begin
    w_rot_idx = '0;
    for (int j = 0; j < p_nchan; j++) begin
      w_rot_idx = w_rot_idx | ({c_iw{w_gnt_rot[j]}} & c_iw'(j));
    end
  end

  // Undo the rotation on the index: (rot_idx + ptr) mod p_nchan
  assign w_sum = {1'b0, w_rot_idx} + {1'b0, ptr};
  assign idx   = (w_sum >= c_n) ? c_iw'(w_sum - c_n) : c_iw'(w_sum);

endmodule : rr_pick
`default_nettype wire

// File: rtl/stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : stream_arb_mux
// Purpose  : N-way val/rdy stream multiplexer. Grants one valid producer per
//            cycle (fixed or round-robin priority) and holds the winner's
//            message in a one-entry pipe-through output register.
// Revision : 1.0 - initial release
// ============================================================================
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter int p_nchan = 4,
  parameter int p_nbits = 8,
  parameter int p_mode  = ARB_RR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [p_nchan-1:0]           in_val,
  output logic [p_nchan-1:0]           in_rdy,
  input  logic [p_nchan*p_nbits-1:0]   in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [p_nbits-1:0]           out_msg,
  output logic [$clog2(p_nchan)-1:0]   out_sel
);

  localparam int c_iw = $clog2(p_nchan);

  logic [p_nchan-1:0] w_grant;
  logic [c_iw-1:0]    w_idx;
  logic [p_nbits-1:0] w_msg;
  logic               w_can_acc;
  logic               w_in_xfer;
  logic               w_out_xfer;

  logic [c_iw-1:0]    r_ptr;
  logic               r_val;
  logic [p_nbits-1:0] r_msg;
  logic [c_iw-1:0]    r_sel;

  rr_pick #(
    .p_nchan (p_nchan)
  ) u_pick (
    .req   (in_val),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  // The register can take a new message when empty or being drained now.
  // in_rdy is gated by rst so producers see no ready while in reset.
  assign w_can_acc  = ~r_val | out_rdy;
  assign in_rdy     = w_grant & {p_nchan{w_can_acc & ~rst}};
  assign w_in_xfer  = |(in_val & in_rdy);
  assign w_out_xfer = r_val & out_rdy;
  assign w_msg      = in_msg[w_idx*p_nbits +: p_nbits];

  // Output register: fill on a channel transfer, else empty on a drain.
  // Written with logic operators / ternaries so unknown handshakes stay X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= 1'b0;
      r_msg <= '0;
      r_sel <= '0;
    end else begin
      r_val <= w_in_xfer | (r_val & ~w_out_xfer);
      r_msg <= w_in_xfer ? w_msg : r_msg;
      r_sel <= w_in_xfer ? w_idx : r_sel;
    end
  end

  generate
    if (p_mode == ARB_RR) begin : g_rr
      logic [c_iw-1:0] w_ptr_next;

      assign w_ptr_next = (w_idx == c_iw'(p_nchan-1)) ? '0 : w_idx + c_iw'(1);

      // Priority pointer moves to the channel after each winner
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_in_xfer ? w_ptr_next : r_ptr;
        end
      end
    end else begin : g_fixed
      // Fixed priority: search always starts at channel 0
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= '0;
        end
      end
    end
  endgenerate

  assign out_val = r_val;
  assign out_msg = r_msg;
  assign out_sel = r_sel;

endmodule : stream_arb_mux
`default_nettype wire

// File: tb/tb_stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arb_mux
// Purpose  : Self-checking bench for stream_arb_mux: one round-robin and one
//            fixed-priority instance, directed scenarios plus random traffic
//            compared against a behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_arb_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_val, in_rdy, f_in_val, f_in_rdy;
  logic [N*W-1:0] in_msg, f_in_msg;
  logic           out_val, out_rdy, f_out_val, f_out_rdy;
  logic [W-1:0]   out_msg, f_out_msg;
  logic [1:0]     out_sel, f_out_sel;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state, index 1 = round-robin DUT, 0 = fixed DUT
  int         m_ptr [2];
  bit         m_val [2];
  logic [W-1:0] m_msg [2];
  int         m_sel [2];

  always #5 clk = ~clk;

  stream_arb_mux #(.p_nchan(N), .p_nbits(W), .p_mode(1)) u_dut_rr (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_sel(out_sel)
  );

  stream_arb_mux #(.p_nchan(N), .p_nbits(W), .p_mode(0)) u_dut_fix (
    .clk(clk), .rst(rst),
    .in_val(f_in_val), .in_rdy(f_in_rdy), .in_msg(f_in_msg),
    .out_val(f_out_val), .out_rdy(f_out_rdy), .out_msg(f_out_msg), .out_sel(f_out_sel)
  );

  // First valid channel searching upward from p with wrap-around, or -1
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy(input int md, input logic [N-1:0] v, input logic ordy);
    int g;
    logic [N-1:0] one;
    one = 1;
    g = pick(v, m_ptr[md]);
    if (g >= 0 && (!m_val[md] || ordy === 1'b1)) return one << g;
    return '0;
  endfunction

  task automatic model_edge(input int md, input logic [N-1:0] v, input logic [N*W-1:0] msgs,
                            input logic ordy);
    int g;
    g = pick(v, m_ptr[md]);
    if (g >= 0 && (!m_val[md] || ordy === 1'b1)) begin
      m_val[md] = 1'b1;
      m_msg[md] = msgs[g*W +: W];
      m_sel[md] = g;
      if (md == 1) m_ptr[md] = (g + 1) % N;
    end else if (m_val[md] && ordy === 1'b1) begin
      m_val[md] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      m_ptr[md] = 0;
      m_val[md] = 1'b0;
      m_msg[md] = '0;
      m_sel[md] = 0;
    end
  endtask

  // One clock: advance the model with the inputs the DUTs sample, then
  // land just after the falling edge where outputs are compared.
  task automatic tick();
    @(posedge clk);
    model_edge(1, in_val, in_msg, out_rdy);
    model_edge(0, f_in_val, f_in_msg, f_out_rdy);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    in_val = 4'b1000; in_msg = 32'h5A00_0000; out_rdy = 1'b0;
    tick();
    in_val = 4'b1111; out_rdy = 1'b1;
    #1;
    n_checks++;
    if (out_val !== 1'b1) $display("FAIL reset_preload out_val=%b expected 1", out_val);
    else n_pass++;
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (out_val !== 1'b0) $display("FAIL reset_out_val got %b expected 0", out_val);
    else n_pass++;
    n_checks++;
    if (out_msg !== 8'h00) $display("FAIL reset_out_msg got %h expected 00", out_msg);
    else n_pass++;
    n_checks++;
    if (out_sel !== 2'd0) $display("FAIL reset_out_sel got %0d expected 0", out_sel);
    else n_pass++;
    n_checks++;
    if (in_rdy !== 4'b0000) $display("FAIL reset_in_rdy got %b expected 0000", in_rdy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; in_val = '0;
    #1;
  endtask

  task automatic test_single();
    in_msg = $urandom;
    in_msg[23:16] = 8'hA5;
    in_val = 4'b0100; out_rdy = 1'b1;
    #1;
    n_checks++;
    if (in_rdy !== 4'b0100) $display("FAIL single_in_rdy got %b expected 0100", in_rdy);
    else n_pass++;
    tick();
    in_val = '0;
    n_checks++;
    if (out_val !== 1'b1 || out_msg !== 8'hA5 || out_sel !== 2'd2)
      $display("FAIL single_out got val=%b msg=%h sel=%0d expected 1/A5/2", out_val, out_msg, out_sel);
    else n_pass++;
  endtask

  task automatic test_rr_fair();
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    do_reset();
    in_val = 4'b1111; in_msg = 32'h1312_1110; out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (out_sel !== 2'(seq[c]) || out_msg !== 8'(8'h10 + seq[c]))
        $display("FAIL rr_fair cycle %0d got sel=%0d msg=%h expected sel=%0d msg=%h",
                 c, out_sel, out_msg, seq[c], 8'(8'h10 + seq[c]));
      else n_pass++;
    end
    in_val = '0;
  endtask

  task automatic test_backpressure();
    in_val = 4'b0010; in_msg = 32'h0000_3C00; out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0; in_val = 4'b1111; in_msg = $urandom;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_rdy !== 4'b0000) $display("FAIL bp_in_rdy cycle %0d got %b expected 0000", c, in_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (out_val !== 1'b1 || out_msg !== 8'h3C || out_sel !== 2'd1)
        $display("FAIL bp_hold cycle %0d got val=%b msg=%h sel=%0d expected 1/3C/1",
                 c, out_val, out_msg, out_sel);
      else n_pass++;
    end
    out_rdy = 1'b1; in_val = 4'b0001; in_msg = 32'h0000_0077;
    #1;
    n_checks++;
    if (in_rdy !== 4'b0001) $display("FAIL bp_release_rdy got %b expected 0001", in_rdy);
    else n_pass++;
    tick();
    in_val = '0;
    n_checks++;
    if (out_val !== 1'b1 || out_msg !== 8'h77 || out_sel !== 2'd0)
      $display("FAIL bp_release_out got val=%b msg=%h sel=%0d expected 1/77/0", out_val, out_msg, out_sel);
    else n_pass++;
  endtask

  task automatic test_fixed();
    f_in_val = 4'b1010; f_out_rdy = 1'b1; f_in_msg = $urandom;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (f_in_rdy !== 4'b0010) $display("FAIL fixed_rdy cycle %0d got %b expected 0010", c, f_in_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (f_out_val !== 1'b1 || f_out_sel !== 2'd1 || f_out_msg !== f_in_msg[15:8])
        $display("FAIL fixed_out cycle %0d got val=%b sel=%0d msg=%h expected 1/1/%h",
                 c, f_out_val, f_out_sel, f_out_msg, f_in_msg[15:8]);
      else n_pass++;
    end
    f_in_val = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] e_rr, e_fx;
    for (int c = 0; c < 300; c++) begin
      in_val    = 4'($urandom);
      in_msg    = $urandom;
      out_rdy   = ($urandom_range(0, 3) != 0);
      f_in_val  = 4'($urandom);
      f_in_msg  = $urandom;
      f_out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      e_rr = exp_rdy(1, in_val, out_rdy);
      e_fx = exp_rdy(0, f_in_val, f_out_rdy);
      n_checks++;
      if (in_rdy !== e_rr || f_in_rdy !== e_fx)
        $display("FAIL rand_rdy cycle %0d got rr=%b fx=%b expected rr=%b fx=%b",
                 c, in_rdy, f_in_rdy, e_rr, e_fx);
      else n_pass++;
      tick();
      n_checks++;
      if (out_val !== m_val[1] || out_msg !== m_msg[1] || out_sel !== 2'(m_sel[1]))
        $display("FAIL rand_rr_out cycle %0d got %b/%h/%0d expected %b/%h/%0d",
                 c, out_val, out_msg, out_sel, m_val[1], m_msg[1], m_sel[1]);
      else n_pass++;
      n_checks++;
      if (f_out_val !== m_val[0] || f_out_msg !== m_msg[0] || f_out_sel !== 2'(m_sel[0]))
        $display("FAIL rand_fx_out cycle %0d got %b/%h/%0d expected %b/%h/%0d",
                 c, f_out_val, f_out_msg, f_out_sel, m_val[0], m_msg[0], m_sel[0]);
      else n_pass++;
    end
    in_val = '0; f_in_val = '0; out_rdy = 1'b1; f_out_rdy = 1'b1;
    tick();
  endtask

  task automatic test_midreset_x();
    logic xin;
    logic [N-1:0] e_rdy;
    in_val = 4'b0100; in_msg = $urandom; out_rdy = 1'b0;
    tick();
    n_checks++;
    if (out_val !== 1'b1) $display("FAIL midrst_loaded out_val=%b expected 1", out_val);
    else n_pass++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (out_val !== 1'b0) $display("FAIL midrst_drop out_val=%b expected 0", out_val);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; in_val = 4'b1111; out_rdy = 1'b1;
    #1;
    n_checks++;
    if (in_rdy !== 4'b0001) $display("FAIL midrst_ch0_rdy got %b expected 0001", in_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_sel !== 2'd0 || out_val !== 1'b1)
      $display("FAIL midrst_ch0_out got sel=%0d val=%b expected 0/1", out_sel, out_val);
    else n_pass++;
    in_val = '0;
    tick();
    n_checks++;
    if (out_val !== 1'b0) $display("FAIL x_empty out_val=%b expected 0", out_val);
    else n_pass++;
    in_val = 'x;
    #1;
    xin = $isunknown(in_val);
    e_rdy = exp_rdy(1, in_val, out_rdy);
    n_checks++;
    if (xin ? !$isunknown(in_rdy) : (in_rdy !== e_rdy))
      $display("FAIL x_in_rdy got %b expected %s", in_rdy, xin ? "X" : "model value");
    else n_pass++;
    @(posedge clk);
    if (!xin) model_edge(1, in_val, in_msg, out_rdy);
    @(negedge clk);
    #1;
    n_checks++;
    if (xin ? !$isunknown(out_val) : (out_val !== m_val[1]))
      $display("FAIL x_out_val got %b expected %s", out_val, xin ? "X" : "model value");
    else n_pass++;
    in_val = '0;
    do_reset();
  endtask

  initial begin
    in_val = '0; in_msg = '0; out_rdy = 1'b1;
    f_in_val = '0; f_in_msg = '0; f_out_rdy = 1'b1;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_single();
    test_rr_fair();
    test_backpressure();
    test_fixed();
    test_random();
    test_midreset_x();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_stream_arb_mux
`default_nettype wire
